// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - 8N1 UART with TX/RX FIFOs, status/control registers and level interrupt
module uart_mmio #(
   parameter int CLK_HZ     = 10000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        we,
   input  logic        re,
   input  logic [3:0]  be,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);
   localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic       wr_en, tx_push_req, tx_push, tx_pop, rx_pop, rx_push, rx_push_req;
   logic       clr_wr, ovr_set, frame_set, tx_busy;
   logic [1:0] ctrl_q;
   logic       ovr_q, frame_q, irq_q;

   assign wr_en       = sel & we & be[0];
   assign tx_push_req = wr_en & (addr[3:2] == 2'd0);
   assign clr_wr      = wr_en & (addr[3:2] == 2'd3);

   // TX FIFO: pointers carry one extra wrap bit to tell full from empty
   logic [7:0]  txf_mem_q [FIFO_DEPTH];
   logic [PW:0] tx_wr_q, tx_rd_q;
   logic        tx_empty, tx_full;
   logic [7:0]  tx_head;

   assign tx_empty = (tx_wr_q == tx_rd_q);
   assign tx_full  = (tx_wr_q[PW] != tx_rd_q[PW]) && (tx_wr_q[PW-1:0] == tx_rd_q[PW-1:0]);
   assign tx_head  = txf_mem_q[tx_rd_q[PW-1:0]];
   assign tx_push  = tx_push_req & (~tx_full | tx_pop);

   always_ff @(posedge clk) begin
      if (tx_push) txf_mem_q[tx_wr_q[PW-1:0]] <= wdata[7:0];
   end

   logic [1:0]    tx_st_q, tx_st_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          tx_q, tx_d;

   assign tx_busy = (tx_st_q != S_IDLE);

   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_d     = tx_q;
      tx_pop   = 1'b0;
      case (tx_st_q)
         S_IDLE: begin
            if (!tx_empty) begin
               tx_pop   = 1'b1;
               tx_sh_d  = tx_head;
               tx_st_d  = S_START;
               tx_cnt_d = '0;
               tx_d     = 1'b0;
            end
         end
         S_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               tx_bit_d = 3'd0;
               tx_st_d  = S_DATA;
               tx_d     = tx_sh_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_st_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                  tx_d     = tx_sh_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               // Chain straight into the next start bit when more data is queued
               if (!tx_empty) begin
                  tx_pop  = 1'b1;
                  tx_sh_d = tx_head;
                  tx_st_d = S_START;
                  tx_d    = 1'b0;
               end else begin
                  tx_st_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // RX: two-flop synchroniser plus one more stage for falling-edge detection
   logic rx_s1_q, rx_s2_q, rx_prev_q;

   logic [7:0]  rxf_mem_q [FIFO_DEPTH];
   logic [PW:0] rx_wr_q, rx_rd_q;
   logic        rx_empty, rx_full;
   logic [7:0]  rx_head;

   assign rx_empty = (rx_wr_q == rx_rd_q);
   assign rx_full  = (rx_wr_q[PW] != rx_rd_q[PW]) && (rx_wr_q[PW-1:0] == rx_rd_q[PW-1:0]);
   assign rx_head  = rxf_mem_q[rx_rd_q[PW-1:0]];
   assign rx_pop   = sel & re & (addr[3:2] == 2'd0) & ~rx_empty;
   assign rx_push  = rx_push_req & (~rx_full | rx_pop);
   assign ovr_set  = rx_push_req & rx_full & ~rx_pop;

   logic [1:0]    rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;

   always_ff @(posedge clk) begin
      if (rx_push) rxf_mem_q[rx_wr_q[PW-1:0]] <= rx_sh_q;
   end

   always_comb begin
      rx_st_d     = rx_st_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_sh_d     = rx_sh_q;
      rx_push_req = 1'b0;
      frame_set   = 1'b0;
      case (rx_st_q)
         S_IDLE: begin
            if (rx_prev_q & ~rx_s2_q) begin
               rx_st_d  = S_START;
               rx_cnt_d = '0;
            end
         end
         S_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = 3'd0;
               rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
               else                  rx_bit_d = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d    = '0;
               rx_st_d     = S_IDLE;
               rx_push_req = rx_s2_q;
               frame_set   = ~rx_s2_q;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         tx_st_q   <= S_IDLE;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         tx_sh_q   <= '0;
         tx_q      <= 1'b1;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         rx_st_q   <= S_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         ctrl_q    <= '0;
         ovr_q     <= 1'b0;
         frame_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
         if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
         tx_st_q   <= tx_st_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_bit_q  <= tx_bit_d;
         tx_sh_q   <= tx_sh_d;
         tx_q      <= tx_d;
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
         if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
         rx_st_q   <= rx_st_d;
         rx_cnt_q  <= rx_cnt_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
         if (wr_en && addr[3:2] == 2'd2) ctrl_q <= wdata[1:0];
         // A set on the same edge as a clear wins
         ovr_q   <= ovr_set   | (ovr_q   & ~(clr_wr & wdata[0]));
         frame_q <= frame_set | (frame_q & ~(clr_wr & wdata[1]));
         irq_q   <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & ~tx_busy);
      end
   end

   always_comb begin
      rdata = '0;
      case (addr[3:2])
         2'd0:    if (!rx_empty) rdata[7:0] = rx_head;
         2'd1:    rdata[5:0] = {frame_q, tx_busy, ovr_q, ~rx_empty, tx_empty, tx_full};
         2'd2:    rdata[1:0] = ctrl_q;
         default: rdata = '0;
      endcase
   end

   assign tx  = tx_q;
   assign irq = irq_q;

   logic unused_bits;
   assign unused_bits = ^{be[3:1], wdata[31:8], addr[1:0]};
endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - randomized self-checking bench for uart_mmio against a frame-level model
module tb_uart_mmio;
   localparam int DIV   = (10000000 + 115200 / 2) / 115200;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0, we = 1'b0, re = 1'b0, rx = 1'b1;
   logic [3:0]  be = 4'h0, addr = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        tx, irq;

   int vec = 0;
   int bad = 0;

   logic [7:0] rxm[$];
   bit         ovr_m = 1'b0;
   bit         frm_m = 1'b0;
   bit         tx_hist[$];

   uart_mmio dut (
      .clk(clk), .rst(rst), .sel(sel), .we(we), .re(re), .be(be), .addr(addr),
      .wdata(wdata), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) tx_hist.push_back(tx);

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] exp_status();
      return {26'b0, frm_m, 1'b0, ovr_m, rxm.size() != 0, 1'b1, 1'b0};
   endfunction

   task automatic do_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk); sel = 1; we = 1; be = 4'h1; addr = a; wdata = d;
      @(negedge clk); sel = 0; we = 0; be = 4'h0;
   endtask

   task automatic peek(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk); sel = 1; we = 0; re = 0; addr = a;
      #1 d = rdata;
      sel = 0;
   endtask

   task automatic pop_read(output logic [31:0] d);
      @(negedge clk); sel = 1; re = 1; we = 0; addr = 4'h0;
      #1 d = rdata;
      @(negedge clk); sel = 0; re = 0;
   endtask

   task automatic send_rx_frame(input logic [7:0] b, input bit stop, output int tv, output int ti);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      tv = -1; ti = -1;
      sel = 1; we = 0; re = 0; addr = 4'h4;
      for (int i = 0; i < 10 * DIV; i++) begin
         @(negedge clk); rx = fr[i / DIV];
         #1;
         if (tv < 0 && rdata[2] === 1'b1) tv = i;
         if (ti < 0 && irq === 1'b1) ti = i;
      end
      @(negedge clk); rx = 1; sel = 0;
      repeat (4) @(negedge clk);
      if (stop) begin
         if (rxm.size() < DEPTH) rxm.push_back(b);
         else ovr_m = 1'b1;
      end else begin
         frm_m = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int txe, irqe;
      rst = 1;
      repeat (5) @(negedge clk);
      vec++; if (tx !== 1'b1 || irq !== 1'b0) begin bad++; $display("FAIL reset_pins got tx=%b irq=%b want tx=1 irq=0", tx, irq); end
      rst = 0;
      peek(4'h4, d); vec++; if (d !== 32'h2) begin bad++; $display("FAIL reset_status got %h want %h", d, 32'h2); end
      peek(4'h8, d); vec++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got %h want 0", d); end
      peek(4'h0, d); vec++; if (d !== 32'h0) begin bad++; $display("FAIL reset_data got %h want 0", d); end
      peek(4'hC, d); vec++; if (d !== 32'h0) begin bad++; $display("FAIL reset_clr got %h want 0", d); end
      txe = 0; irqe = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1) txe++;
         if (irq !== 1'b0) irqe++;
      end
      vec++; if (txe != 0) begin bad++; $display("FAIL reset_tx_idle got %0d low cycles want 0", txe); end
      vec++; if (irqe != 0) begin bad++; $display("FAIL reset_irq got %0d high cycles want 0", irqe); end
   endtask

   task automatic test_tx_single(input logic [7:0] b);
      logic [9:0]  fr;
      logic [31:0] d;
      int errs[10];
      int busy_err;
      fr = {1'b1, b, 1'b0};
      busy_err = 0;
      for (int k = 0; k < 10; k++) errs[k] = 0;
      do_write(4'h0, {24'b0, b});
      vec++; if (tx !== 1'b1) begin bad++; $display("FAIL tx_early got tx=%b want 1", tx); end
      sel = 0; addr = 4'h4;
      for (int i = 0; i < 10 * DIV; i++) begin
         @(negedge clk); #1;
         if (tx !== fr[i / DIV]) errs[i / DIV]++;
         if (rdata[4] !== 1'b1) busy_err++;
      end
      for (int k = 0; k < 10; k++) begin
         vec++; if (errs[k] != 0) begin bad++; $display("FAIL tx_bit%0d byte %h got %0d wrong cycles want 0", k, b, errs[k]); end
      end
      vec++; if (busy_err != 0) begin bad++; $display("FAIL tx_busy got %0d idle cycles want 0", busy_err); end
      peek(4'h4, d); vec++; if (d !== 32'h2) begin bad++; $display("FAIL tx_done_status got %h want %h", d, 32'h2); end
   endtask

   task automatic test_tx_irq();
      logic [31:0] d;
      do_write(4'h8, 32'h2);
      vec++; if (irq !== 1'b0) begin bad++; $display("FAIL txirq_latency got %b want 0", irq); end
      @(negedge clk);
      vec++; if (irq !== 1'b1) begin bad++; $display("FAIL txirq_rise got %b want 1", irq); end
      peek(4'h8, d); vec++; if (d !== 32'h2) begin bad++; $display("FAIL ctrl_readback got %h want 2", d); end
      do_write(4'h0, {24'b0, 8'($urandom)});
      @(negedge clk);
      vec++; if (irq !== 1'b0) begin bad++; $display("FAIL txirq_busy got %b want 0", irq); end
      repeat (10 * DIV + 3) @(negedge clk);
      vec++; if (irq !== 1'b1) begin bad++; $display("FAIL txirq_done got %b want 1", irq); end
      do_write(4'h8, 32'h0);
      @(negedge clk);
      vec++; if (irq !== 1'b0) begin bad++; $display("FAIL txirq_off got %b want 0", irq); end
   endtask

   task automatic test_back_to_back(input int n, input bit seq);
      logic [7:0] data[8];
      logic [7:0] got;
      int start, idx, prev, nexp, zeros;
      bit framing;
      for (int k = 0; k < n; k++) data[k] = seq ? 8'(k + 1) : 8'($urandom);
      // The idle FSM drains the first byte one edge after it lands, so DEPTH+1 bytes fit
      nexp = (n < DEPTH + 1) ? n : DEPTH + 1;
      @(negedge clk);
      start = tx_hist.size();
      for (int k = 0; k < n; k++) begin
         sel = 1; we = 1; be = 4'h1; addr = 4'h0; wdata = {24'b0, data[k]};
         @(negedge clk);
      end
      sel = 0; we = 0; be = 4'h0;
      repeat (nexp * 10 * DIV + 1000) @(negedge clk);
      idx = start; prev = -1;
      for (int f = 0; f < nexp; f++) begin
         while (idx < tx_hist.size() && !(tx_hist[idx - 1] == 1'b1 && tx_hist[idx] == 1'b0)) idx++;
         vec++;
         if (idx >= tx_hist.size()) begin
            bad++; $display("FAIL b2b_frame_missing n=%0d frame %0d got none want start bit", n, f);
            break;
         end
         framing = (tx_hist[idx + DIV / 2] == 1'b0) && (tx_hist[idx + DIV / 2 + 9 * DIV] == 1'b1);
         for (int b = 0; b < 8; b++) got[b] = tx_hist[idx + DIV / 2 + DIV * (b + 1)];
         vec++; if (got !== data[f]) begin bad++; $display("FAIL b2b_byte frame %0d got %h want %h", f, got, data[f]); end
         vec++; if (!framing) begin bad++; $display("FAIL b2b_framing frame %0d got bad start/stop want 0/1", f); end
         if (prev >= 0) begin
            vec++; if (idx - prev != 10 * DIV) begin bad++; $display("FAIL b2b_gap frame %0d got %0d want %0d", f, idx - prev, 10 * DIV); end
         end
         prev = idx;
         idx = idx + 9 * DIV + DIV / 2 + 1;
      end
      zeros = 0;
      for (int i = idx; i < tx_hist.size(); i++) if (tx_hist[i] == 1'b0) zeros++;
      vec++; if (zeros != 0) begin bad++; $display("FAIL b2b_extra n=%0d got %0d low cycles after last frame want 0", n, zeros); end
   endtask

   task automatic test_rx();
      logic [7:0]  b;
      logic [31:0] d;
      int tv, ti;
      b = 8'($urandom);
      do_write(4'h8, 32'h1);
      send_rx_frame(b, 1'b1, tv, ti);
      vec++; if (tv < 0) begin bad++; $display("FAIL rx_valid_set got never want set"); end
      vec++; if (ti != tv + 1) begin bad++; $display("FAIL rx_irq_latency got %0d want %0d", ti, tv + 1); end
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL rx_status got %h want %h", d, exp_status()); end
      pop_read(d);
      vec++; if (d !== {24'b0, b}) begin bad++; $display("FAIL rx_data got %h want %h", d, {24'b0, b}); end
      rxm.delete();
      vec++; if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq_hold got %b want 1", irq); end
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL rx_status_popped got %h want %h", d, exp_status()); end
      vec++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_fall got %b want 0", irq); end
      pop_read(d);
      vec++; if (d !== 32'h0) begin bad++; $display("FAIL rx_empty_pop got %h want 0", d); end
      do_write(4'h8, 32'h0);
   endtask

   task automatic test_overrun();
      logic [7:0]  b, e;
      logic [31:0] d;
      int tv, ti;
      for (int k = 0; k < DEPTH + 1; k++) begin
         b = 8'($urandom);
         send_rx_frame(b, 1'b1, tv, ti);
      end
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL ovr_status got %h want %h", d, exp_status()); end
      for (int k = 0; k < DEPTH; k++) begin
         e = rxm.pop_front();
         pop_read(d);
         vec++; if (d !== {24'b0, e}) begin bad++; $display("FAIL ovr_data%0d got %h want %h", k, d, {24'b0, e}); end
      end
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL ovr_drained got %h want %h", d, exp_status()); end
      do_write(4'hC, 32'h1);
      ovr_m = 1'b0;
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL ovr_clear got %h want %h", d, exp_status()); end
   endtask

   task automatic test_frame_glitch();
      logic [7:0]  b, e;
      logic [31:0] d;
      int tv, ti;
      send_rx_frame(8'($urandom), 1'b0, tv, ti);
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL frame_err got %h want %h", d, exp_status()); end
      @(negedge clk); rx = 0;
      repeat (20) @(negedge clk);
      rx = 1;
      repeat (200) @(negedge clk);
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL glitch got %h want %h", d, exp_status()); end
      b = 8'($urandom);
      send_rx_frame(b, 1'b1, tv, ti);
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL post_glitch_status got %h want %h", d, exp_status()); end
      e = rxm.pop_front();
      pop_read(d);
      vec++; if (d !== {24'b0, e}) begin bad++; $display("FAIL post_glitch_data got %h want %h", d, {24'b0, e}); end
      do_write(4'hC, 32'h2);
      frm_m = 1'b0;
      peek(4'h4, d); vec++; if (d !== exp_status()) begin bad++; $display("FAIL frame_clear got %h want %h", d, exp_status()); end
   endtask

   task automatic test_reset_mid_tx();
      logic [31:0] d;
      int txe;
      do_write(4'h0, 32'h0);
      do_write(4'h0, {24'b0, 8'($urandom)});
      repeat (300) @(negedge clk);
      vec++; if (tx !== 1'b0) begin bad++; $display("FAIL midtx_line got %b want 0", tx); end
      #2 rst = 1;
      #1;
      vec++; if (tx !== 1'b1) begin bad++; $display("FAIL midtx_async_tx got %b want 1", tx); end
      peek(4'h4, d); vec++; if (d !== 32'h2) begin bad++; $display("FAIL midtx_status_in_reset got %h want %h", d, 32'h2); end
      @(negedge clk); rst = 0;
      txe = 0;
      repeat (1200) begin
         @(negedge clk);
         if (tx !== 1'b1) txe++;
      end
      vec++; if (txe != 0) begin bad++; $display("FAIL midtx_resume got %0d low cycles want 0", txe); end
      peek(4'h4, d); vec++; if (d !== 32'h2) begin bad++; $display("FAIL midtx_status got %h want %h", d, 32'h2); end
   endtask

   initial begin
      test_reset();
      test_tx_single(8'h55);
      test_tx_single(8'($urandom));
      test_tx_irq();
      test_back_to_back(6, 1'b1);
      test_back_to_back(int'($urandom_range(1, 7)), 1'b0);
      test_back_to_back(int'($urandom_range(1, 7)), 1'b0);
      test_rx();
      test_overrun();
      test_frame_glitch();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
